// File: rtl/fft_result_reader.sv
// Streams one N-word frame out of the FFT work RAM, optionally in bit-reversed order.
// A 2-entry FIFO covers the one-cycle RAM read latency under sink backpressure.
module fft_result_reader #(
  parameter int IWL         = 32,
  parameter int AWL         = 5,
  parameter int BIT_REVERSE = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_START,
  output logic           o_RAM_EN,
  output logic [AWL-1:0] o_RAM_ADDR,
  input  logic [IWL-1:0] i_RAM_DATA,
  output logic [IWL-1:0] o_DATA,
  output logic           o_VALID,
  input  logic           i_READY,
  output logic           o_LAST,
  output logic           o_BUSY,
  output logic           o_DONE
);

  localparam int N = 1 << AWL;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t         state_q;
  logic [AWL:0]   idx_q;
  logic           inflight_q;
  logic           infl_last_q;
  logic [IWL-1:0] dat_q [2];
  logic [1:0]     tag_q;
  logic           rd_q;
  logic           wr_q;
  logic [1:0]     cnt_q;
  logic [1:0]     cnt_d;
  logic           done_q;

  logic           pop;
  logic           push;
  logic           issue;
  logic           is_last_idx;
  logic [AWL-1:0] idx_lo;
  logic [AWL-1:0] idx_rev;
  logic [2:0]     outstanding;

  assign idx_lo      = idx_q[AWL-1:0];
  assign is_last_idx = (idx_q == (AWL+1)'(N-1));

  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < AWL; i++) begin
      idx_rev[i] = idx_lo[AWL-1-i];
    end
  end

  assign o_VALID     = (cnt_q != 2'd0);
  assign pop         = o_VALID & i_READY;
  assign push        = inflight_q;
  assign outstanding = {1'b0, cnt_q} + {2'b00, inflight_q};

  // A slot freed by this cycle's pop may be refilled by a read issued now.
  assign issue = (state_q == READ) &
                 ((outstanding < 3'd2) | pop);

  assign o_RAM_EN   = issue;
  assign o_RAM_ADDR = issue ?
                      ((BIT_REVERSE != 0) ? idx_rev : idx_lo) :
                      '0;

  assign o_DATA = o_VALID ? dat_q[rd_q] : '0;
  assign o_LAST = o_VALID & tag_q[rd_q];
  assign o_BUSY = (state_q != IDLE);
  assign o_DONE = done_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      dat_q[0]    <= '0;
      dat_q[1]    <= '0;
      tag_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      inflight_q  <= issue;
      infl_last_q <= issue & is_last_idx;
      cnt_q       <= cnt_d;
      if (issue) begin
        idx_q <= idx_q + (AWL+1)'(1);
      end
      if (push) begin
        dat_q[wr_q] <= i_RAM_DATA;
        tag_q[wr_q] <= infl_last_q;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      unique case (state_q)
        IDLE: begin
          if (i_START) begin
            state_q     <= READ;
            idx_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
          end
        end
        READ: begin
          if (issue && is_last_idx) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && o_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench: two readers (bit-reversed and linear) against RAM models and a
// transfer-level reference of the expected word order.
module tb_fft_result_reader;

  localparam int AWL = 5;
  localparam int N   = 32;
  localparam int IWL = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;

  always #5 CLK = ~CLK;

  logic [1:0]     en_w, valid_w, last_w, busy_w, done_w;
  logic [AWL-1:0] addr_w [2];
  logic [IWL-1:0] data_w [2];
  logic [IWL-1:0] rdata  [2];
  logic [IWL-1:0] mem    [2][N];

  fft_result_reader #(.IWL(IWL), .AWL(AWL), .BIT_REVERSE(1)) u_br (
    .CLK(CLK), .RST(RST), .i_START(start),
    .o_RAM_EN(en_w[0]), .o_RAM_ADDR(addr_w[0]),
    .i_RAM_DATA(rdata[0]), .o_DATA(data_w[0]),
    .o_VALID(valid_w[0]), .i_READY(ready),
    .o_LAST(last_w[0]), .o_BUSY(busy_w[0]), .o_DONE(done_w[0])
  );

  fft_result_reader #(.IWL(IWL), .AWL(AWL), .BIT_REVERSE(0)) u_lin (
    .CLK(CLK), .RST(RST), .i_START(start),
    .o_RAM_EN(en_w[1]), .o_RAM_ADDR(addr_w[1]),
    .i_RAM_DATA(rdata[1]), .o_DATA(data_w[1]),
    .o_VALID(valid_w[1]), .i_READY(ready),
    .o_LAST(last_w[1]), .o_BUSY(busy_w[1]), .o_DONE(done_w[1])
  );

  // Synchronous-read RAM models
  always @(posedge CLK) if (en_w[0]) rdata[0] <= mem[0][addr_w[0]];
  always @(posedge CLK) if (en_w[1]) rdata[1] <= mem[1][addr_w[1]];

  int checks = 0;
  int errors = 0;
  int cn;
  int pos[2], iss[2], done_cnt[2], first_v[2];
  int en_first[2], en_last[2], en_cnt[2], done_cyc[2], vcnt[2];
  int en_at10[2];
  logic active[2];
  logic stall_prev[2];
  logic [IWL-1:0] prev_data[2];
  logic [IWL-1:0] seq[2][N];

  function automatic logic [AWL-1:0] bitrev(input logic [AWL-1:0] a);
    logic [AWL-1:0] r;
    for (int i = 0; i < AWL; i++) r[i] = a[AWL-1-i];
    return r;
  endfunction

  function automatic logic [IWL-1:0] expw(input int d, input int p);
    logic [AWL-1:0] k;
    k = (d == 0) ? bitrev(5'(p)) : 5'(p);
    return mem[d][k];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic new_frame();
    cn = -1;
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; iss[d] = 0; done_cnt[d] = 0; first_v[d] = -1;
      en_first[d] = -1; en_last[d] = -1; en_cnt[d] = 0;
      done_cyc[d] = -1; vcnt[d] = 0; en_at10[d] = -1;
      active[d] = 1'b0; stall_prev[d] = 1'b0; prev_data[d] = '0;
    end
  endtask

  task automatic mon();
    for (int d = 0; d < 2; d++) begin
      if (!RST) begin
        chk("rst_en", {31'b0, en_w[d]}, 0);
        chk("rst_addr", {27'b0, addr_w[d]}, 0);
        chk("rst_data", data_w[d], 0);
        chk("rst_flags", {28'b0, valid_w[d], last_w[d], busy_w[d], done_w[d]}, 0);
        continue;
      end
      if (en_w[d]) begin
        chk("addr", {27'b0, addr_w[d]},
            {27'b0, (d == 0) ? bitrev(5'(iss[d])) : 5'(iss[d])});
        chk("issue_range", iss[d] < N, 1);
        iss[d]++;
        en_cnt[d]++;
        if (en_first[d] < 0) en_first[d] = cn;
        en_last[d] = cn;
      end else begin
        chk("addr_idle", {27'b0, addr_w[d]}, 0);
      end
      chk("last", {31'b0, last_w[d]}, valid_w[d] && pos[d] == N-1);
      if (stall_prev[d]) begin
        chk("hold_valid", {31'b0, valid_w[d]}, 1);
        chk("hold_data", data_w[d], prev_data[d]);
      end
      if (valid_w[d]) begin
        vcnt[d]++;
        if (first_v[d] < 0) first_v[d] = cn;
        if (pos[d] < N) begin
          chk("data", data_w[d], expw(d, pos[d]));
          seq[d][pos[d]] = data_w[d];
        end else begin
          chk("extra_word", 1, 0);
        end
      end
      if (valid_w[d] && ready) pos[d]++;
      chk("outstanding", (iss[d] - pos[d]) <= 2, 1);
      stall_prev[d] = valid_w[d] && !ready;
      prev_data[d] = data_w[d];
      if (done_w[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cn;
        chk("done_pos", pos[d], N);
        chk("busy_at_done", {31'b0, busy_w[d]}, 0);
        active[d] = 1'b0;
      end else begin
        chk("busy", {31'b0, busy_w[d]}, {31'b0, active[d]});
      end
    end
  endtask

  task automatic cyc(input logic st, input logic rdy);
    @(posedge CLK);
    #1;
    start = st;
    ready = rdy;
    cn++;
    @(negedge CLK);
    mon();
  endtask

  // mode 0: ready high; 1: ready low 10 cycles; 2: random; 3: second start
  task automatic run_frame(input int mode);
    logic r;
    new_frame();
    cyc(1'b1, mode != 1);
    active[0] = 1'b1;
    active[1] = 1'b1;
    for (int c = 1; c < 400; c++) begin
      case (mode)
        1:       r = (c > 10);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      cyc(mode == 3 && c == 10, r);
      if (c == 10) begin
        en_at10[0] = en_cnt[0];
        en_at10[1] = en_cnt[1];
      end
      if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'($urandom_range(0, 1)));
    for (int d = 0; d < 2; d++) begin
      chk("frame_done_count", done_cnt[d], 1);
      chk("frame_words", pos[d], N);
      chk("frame_issues", iss[d], N);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mem[0][k] = k;
      mem[1][k] = k;
    end
    new_frame();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(posedge CLK);
    #1 RST = 1'b1;
    cyc(1'b0, 1'b0);

    // Ready held high, RAM[k]=k
    run_frame(0);
    for (int d = 0; d < 2; d++) begin
      chk("latency", first_v[d], 3);
      chk("en_first", en_first[d], 1);
      chk("en_last", en_last[d], 32);
      chk("en_cnt", en_cnt[d], 32);
      chk("valid_cycles", vcnt[d], 32);
      chk("done_cycle", done_cyc[d], 35);
    end
    chk("br_w1", seq[0][1], 16);
    chk("br_w2", seq[0][2], 8);
    chk("br_w3", seq[0][3], 24);
    chk("br_w4", seq[0][4], 4);
    chk("br_w31", seq[0][31], 31);
    chk("lin_w7", seq[1][7], 7);

    // Ready low for the first 10 cycles
    run_frame(1);
    chk("bp_issues_br", en_at10[0], 2);
    chk("bp_issues_lin", en_at10[1], 2);
    chk("bp_first", seq[0][0], 0);

    // Second start inside a frame
    run_frame(3);

    // Random contents, random backpressure
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        mem[0][k] = $urandom;
        mem[1][k] = $urandom;
      end
      run_frame(2);
    end

    // Reset mid-frame
    for (int k = 0; k < N; k++) begin
      mem[0][k] = k;
      mem[1][k] = k;
    end
    new_frame();
    cyc(1'b1, 1'b1);
    active[0] = 1'b1;
    active[1] = 1'b1;
    for (int c = 1; c <= 15; c++) cyc(1'b0, 1'b1);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("async_rst_en", {30'b0, en_w}, 0);
    chk("async_rst_valid", {30'b0, valid_w}, 0);
    chk("async_rst_busy", {30'b0, busy_w}, 0);
    chk("async_rst_data", data_w[0] | data_w[1], 0);
    active[0] = 1'b0;
    active[1] = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    @(posedge CLK);
    #1 RST = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("no_done_after_rst", done_cnt[0] + done_cnt[1], 0);
    run_frame(0);
    for (int d = 0; d < 2; d++) begin
      chk("rst_latency", first_v[d], 3);
      chk("rst_done_cycle", done_cyc[d], 35);
    end
    chk("rst_br_w1", seq[0][1], 16);
    chk("rst_lin_w0", seq[1][0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
